score_bcd: RTL



---
 rtl/score_bcd.sv | 108 ++++++++++
 1 files changed

// File: rtl/score_bcd.sv
// score_bcd: sequential binary-to-BCD converter (double-dabble, one bit per cycle).
// A score is accepted over a valid/ready handshake, clamped to 9999, then
// converted.  The four BCD digit registers are updated together on the LOAD
// edge, so the display never shows a partially converted value.
module score_bcd #(
    parameter int BIN_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIN_WIDTH-1:0] bin_score,
    output logic [3:0]           score_1,
    output logic [3:0]           score_2,
    output logic [3:0]           score_3,
    output logic [3:0]           score_4,
    output logic                 done
);

    localparam int CW = (BIN_WIDTH > 16) ? 5 : 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    localparam logic [BIN_WIDTH-1:0] MAX_SCORE = BIN_WIDTH'(9999);
    localparam logic [CW-1:0]        LAST_CNT  = CW'(BIN_WIDTH - 1);

    logic [1:0]           r_state;
    logic [BIN_WIDTH-1:0] r_bin;
    logic [15:0]          r_bcd;
    logic [CW-1:0]        r_cnt;
    logic [15:0]          r_score;
    logic                 r_done;

    logic [BIN_WIDTH-1:0]    w_sat;
    logic [15:0]             w_adj;
    logic [16+BIN_WIDTH-1:0] w_shifted;

    // Clamp the incoming score; the compare runs at full input width.
    always_comb begin
        w_sat = (bin_score > MAX_SCORE) ? MAX_SCORE : bin_score;
    end

    // Add-3 on every BCD nibble >= 5 (all from pre-adjust values), then shift.
    always_comb begin
        w_adj = r_bcd;
        for (int n = 0; n < 4; n++) begin
            if (r_bcd[n*4 +: 4] >= 4'd5) begin
                w_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
            end
        end
        w_shifted = {w_adj, r_bin} << 1;
    end

    // Control FSM, shift datapath and atomic digit publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_score <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_bin   <= w_sat;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= w_shifted[16+BIN_WIDTH-1 -: 16];
                    r_bin <= w_shifted[BIN_WIDTH-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    // Counter value LAST_CNT marks the final (BIN_WIDTH-th) shift.
                    if (r_cnt == LAST_CNT) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_score <= r_bcd;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready only while idle; goes high in the same cycle done is high.
    always_comb begin
        in_ready = (r_state == ST_IDLE);
    end

    assign score_1 = r_score[3:0];
    assign score_2 = r_score[7:4];
    assign score_3 = r_score[11:8];
    assign score_4 = r_score[15:12];
    assign done    = r_done;

endmodule
